// File: rtl/stage_writeback_pipe.sv
// stage_writeback_pipe: vector data memory, sideband alignment to the memory
// read latency, and register-file writeback select. One instruction per cycle,
// stall holds every stage, flush/reset clear the valid bits.

// One lane of the vector data memory. The lane write enable already carries
// the accept qualification and the lane mask. The read side is write-first and
// has memLatency registered stages. All of them hold while advance is low.
module stage_writeback_lane #(
    parameter int registerSize = 8,
    parameter int addrWidth    = 8,
    parameter int memLatency   = 1
) (
    input  logic                    clk,
    input  logic                    advance,
    input  logic                    writeEn,
    input  logic [addrWidth-1:0]    addr,
    input  logic [registerSize-1:0] writeData,
    output logic [registerSize-1:0] readData
);
    logic [registerSize-1:0] mem [2**addrWidth];
    logic [registerSize-1:0] rdPipe [memLatency];

    // Array write. Contents are never cleared, so data survives a reset.
    always_ff @(posedge clk) begin
        if (writeEn) mem[addr] <= writeData;
    end

    // Array output register (write-first on a masked lane), then the extra
    // latency stages. A read is issued on every advancing cycle.
    always_ff @(posedge clk) begin
        if (advance) begin
            rdPipe[0] <= writeEn ? writeData : mem[addr];
            for (int k = 1; k < memLatency; k++) rdPipe[k] <= rdPipe[k-1];
        end
    end

    assign readData = rdPipe[memLatency-1];
endmodule

// Top: memLatency must be in 1..4. addrWidth must not exceed registerSize.
module stage_writeback_pipe #(
    parameter int vecSize      = 4,
    parameter int registerSize = 8,
    parameter int addrWidth    = 8,
    parameter int memLatency   = 1,
    parameter int regIdxWidth  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            valid_in,
    input  logic                            memWrite,
    input  logic [vecSize-1:0]              laneMask,
    input  logic                            addrFromReg,
    input  logic [1:0]                      writeRegFrom,
    input  logic                            regWrite,
    input  logic [regIdxWidth-1:0]          destReg,
    input  logic [registerSize-1:0]         imm,
    input  logic [registerSize-1:0]         alu_operand2,
    input  logic [vecSize*registerSize-1:0] writeData,
    input  logic [vecSize*registerSize-1:0] aluResult,
    output logic                            wb_valid,
    output logic                            wb_regWrite,
    output logic [regIdxWidth-1:0]          wb_destReg,
    output logic [vecSize*registerSize-1:0] writeBackData
);
    typedef logic [vecSize-1:0][registerSize-1:0] vec_t;

    // Everything that travels alongside the memory read. The immediate is
    // kept scalar and only replicated at the output mux.
    typedef struct packed {
        logic                    regWrite;
        logic [regIdxWidth-1:0]  destReg;
        logic [1:0]              writeRegFrom;
        vec_t                    aluResult;
        logic [registerSize-1:0] imm;
    } side_t;

    logic [memLatency:1]  vldPipe;
    side_t                sidePipe [1:memLatency];
    side_t                sideIn;
    side_t                outSide;
    vec_t                 wdVec;
    vec_t                 memVec;
    vec_t                 selVec;
    logic [addrWidth-1:0] memAddr;
    logic                 acceptWrite;

    assign wdVec = writeData;

    // Upper operand bits are dropped, which wraps the address space.
    assign memAddr = addrFromReg ? addrWidth'(alu_operand2) : addrWidth'(imm);

    // Writes only land for an accepted instruction. Reset and flush discard it.
    assign acceptWrite = valid_in && memWrite && !stall && !flush && !reset;

    // Gather the sideband fields entering the pipe this cycle.
    always_comb begin
        sideIn              = '0;
        sideIn.regWrite     = regWrite;
        sideIn.destReg      = destReg;
        sideIn.writeRegFrom = writeRegFrom;
        sideIn.aluResult    = aluResult;
        sideIn.imm          = imm;
    end

    // Valid shift register. Reset and flush clear every stage. Stall holds.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vldPipe <= '0;
        end else if (!stall) begin
            vldPipe[1] <= valid_in;
            for (int k = 2; k <= memLatency; k++) vldPipe[k] <= vldPipe[k-1];
        end
    end

    // Sideband data stages. Stale data is harmless because the outputs are
    // gated by the valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            sidePipe[1] <= sideIn;
            for (int k = 2; k <= memLatency; k++) sidePipe[k] <= sidePipe[k-1];
        end
    end

    for (genvar i = 0; i < vecSize; i++) begin : gLane
        stage_writeback_lane #(
            .registerSize(registerSize),
            .addrWidth   (addrWidth),
            .memLatency  (memLatency)
        ) uLane (
            .clk      (clk),
            .advance  (!stall),
            .writeEn  (acceptWrite && laneMask[i]),
            .addr     (memAddr),
            .writeData(wdVec[i]),
            .readData (memVec[i])
        );
    end

    assign outSide     = sidePipe[memLatency];
    assign wb_valid    = vldPipe[memLatency];
    assign wb_regWrite = wb_valid && outSide.regWrite;
    assign wb_destReg  = wb_valid ? outSide.destReg : '0;

    // Writeback select on the delayed code. Every code has a defined value,
    // and an empty slot drives zero.
    always_comb begin
        selVec = '0;
        case (outSide.writeRegFrom)
            2'd0: selVec = memVec;
            2'd1: selVec = outSide.aluResult;
            2'd2: for (int i = 0; i < vecSize; i++) selVec[i] = outSide.imm;
            default: for (int i = 0; i < vecSize; i++) selVec[i] = outSide.aluResult[0];
        endcase
        writeBackData = wb_valid ? selVec : '0;
    end
endmodule

// File: tb/tb_stage_writeback_pipe.sv
// Bench for stage_writeback_pipe. Instance A uses the default parameters
// (latency 1, 256 words). Instance B uses latency 3 and 64 words, so its
// addresses alias. Both instances share all inputs. The reference model is a
// word-level memory plus one delay queue per instance.
module tb_stage_writeback_pipe;
    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, memWrite, addrFromReg, regWrite;
    logic [3:0]  laneMask, destReg;
    logic [1:0]  writeRegFrom;
    logic [7:0]  imm, alu_operand2;
    logic [31:0] writeData, aluResult;

    logic        wbValidA, wbRegWriteA, wbValidB, wbRegWriteB;
    logic [3:0]  wbDestA, wbDestB;
    logic [31:0] wbDataA, wbDataB;
    logic [37:0] obsA, obsB, expA, expB;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        qA[$];
    ent_t        qB[$];
    logic [31:0] memA [256];
    logic [31:0] memB [64];

    always #5 clk = ~clk;

    stage_writeback_pipe #(.memLatency(1), .addrWidth(8)) dutA (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .memWrite(memWrite), .laneMask(laneMask), .addrFromReg(addrFromReg),
        .writeRegFrom(writeRegFrom), .regWrite(regWrite), .destReg(destReg), .imm(imm),
        .alu_operand2(alu_operand2), .writeData(writeData), .aluResult(aluResult),
        .wb_valid(wbValidA), .wb_regWrite(wbRegWriteA), .wb_destReg(wbDestA),
        .writeBackData(wbDataA));

    stage_writeback_pipe #(.memLatency(3), .addrWidth(6)) dutB (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .memWrite(memWrite), .laneMask(laneMask), .addrFromReg(addrFromReg),
        .writeRegFrom(writeRegFrom), .regWrite(regWrite), .destReg(destReg), .imm(imm),
        .alu_operand2(alu_operand2), .writeData(writeData), .aluResult(aluResult),
        .wb_valid(wbValidB), .wb_regWrite(wbRegWriteB), .wb_destReg(wbDestB),
        .writeBackData(wbDataB));

    assign obsA = {wbValidA, wbRegWriteA, wbDestA, wbDataA};
    assign obsB = {wbValidB, wbRegWriteB, wbDestB, wbDataB};

    task automatic drive(input logic v, input logic mw, input logic [3:0] mask,
                         input logic afr, input logic [1:0] wrf, input logic rw,
                         input logic [3:0] dest, input logic [7:0] im, input logic [7:0] op2,
                         input logic [31:0] wd, input logic [31:0] alu);
        valid_in = v; memWrite = mw; laneMask = mask; addrFromReg = afr;
        writeRegFrom = wrf; regWrite = rw; destReg = dest; imm = im;
        alu_operand2 = op2; writeData = wd; aluResult = alu;
        stall = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0);
    endtask

    // Apply one clock edge to the model. Then set expA/expB to what each
    // instance must show after that edge.
    task automatic tick();
        ent_t       eA, eB;
        logic       acc;
        logic [7:0] aA;
        logic [5:0] aB;
        @(posedge clk);
        acc = valid_in && !stall && !flush && !reset;
        aA  = addrFromReg ? alu_operand2 : imm;
        aB  = aA[5:0];
        if (acc && memWrite)
            for (int i = 0; i < 4; i++)
                if (laneMask[i]) begin
                    memA[aA][8*i +: 8] = writeData[8*i +: 8];
                    memB[aB][8*i +: 8] = writeData[8*i +: 8];
                end
        eA.v = valid_in; eA.rw = regWrite; eA.dest = destReg;
        case (writeRegFrom)
            2'd0: eA.data = memA[aA];
            2'd1: eA.data = aluResult;
            2'd2: eA.data = {4{imm}};
            default: eA.data = {4{aluResult[7:0]}};
        endcase
        eB = eA;
        if (writeRegFrom == 2'd0) eB.data = memB[aB];
        if (!stall) begin
            qA.push_front(eA); void'(qA.pop_back());
            qB.push_front(eB); void'(qB.pop_back());
        end
        if (reset || flush) begin
            foreach (qA[k]) qA[k].v = 1'b0;
            foreach (qB[k]) qB[k].v = 1'b0;
        end
        expA = qA[$].v ? qA[$] : '0;
        expB = qB[$].v ? qB[$] : '0;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 1'b1, 4'h3, 8'h00, 8'h00, 32'h0, 32'h12345678);
        reset = 1'b1;
        repeat (2) begin
            tick();
            vectors++;
            if ({obsA, obsB} !== 76'h0) begin
                miscompares++;
                $display("FAIL reset got A=%h B=%h want 0", obsA, obsB);
            end
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 256; a++) begin
            drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, a[3:0], a[7:0], 8'h00, $urandom, $urandom);
            tick();
            vectors++;
            if ({obsA, obsB} !== {expA, expB}) begin
                miscompares++;
                $display("FAIL fill got A=%h B=%h want A=%h B=%h", obsA, obsB, expA, expB);
            end
        end
    endtask

    task automatic drain(input string name);
        idle();
        repeat (3) begin
            tick();
            vectors++;
            if ({obsA, obsB} !== {expA, expB}) begin
                miscompares++;
                $display("FAIL %s_drain got A=%h B=%h want A=%h B=%h", name, obsA, obsB, expA, expB);
            end
        end
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h10, 8'h00, 32'h04030201, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h5, 8'h10, 8'h00, 32'h0, 32'h0);
        tick();
        vectors++;
        if (obsA !== {1'b1, 1'b1, 4'd5, 32'h04030201}) begin
            miscompares++;
            $display("FAIL store_load got=%h want=%h", obsA, {1'b1, 1'b1, 4'd5, 32'h04030201});
        end
        drain("store_load");
    endtask

    task automatic test_partial_mask();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h20, 8'h00, 32'h08080808, 32'h0);
        tick();
        drive(1'b1, 1'b1, 4'b0101, 1'b0, 2'd1, 1'b0, 4'h0, 8'h20, 8'h00, 32'h01020304, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h6, 8'h20, 8'h00, 32'h0, 32'h0);
        tick();
        vectors++;
        if (obsA !== {1'b1, 1'b1, 4'd6, 32'h08020804}) begin
            miscompares++;
            $display("FAIL partial_mask got=%h want=%h", obsA, {1'b1, 1'b1, 4'd6, 32'h08020804});
        end
        drain("partial_mask");
    endtask

    task automatic test_broadcast();
        logic [31:0] want [3];
        want[0] = 32'h5A5A5A5A; want[1] = 32'h33333333; want[2] = 32'h09070633;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b0, (k == 0) ? 2'd2 : (k == 1) ? 2'd3 : 2'd1, 1'b1,
                  4'(7 + k), 8'h5A, 8'h00, 32'h0, 32'h09070633);
            tick();
            vectors++;
            if (obsA !== {1'b1, 1'b1, 4'(7 + k), want[k]}) begin
                miscompares++;
                $display("FAIL broadcast%0d got=%h want=%h", k, obsA, {1'b1, 1'b1, 4'(7 + k), want[k]});
            end
        end
        drain("broadcast");
    endtask

    task automatic test_latency3();
        logic [3:0] wantDest [8];
        logic       wantV    [8];
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 4'(k + 1), 8'h00, 8'(8'h44 + k), 32'h0, 32'h0);
            tick();
        end
        // After the 3rd issue edge B shows d1. Two stall edges hold it, then d2, d3, empty.
        wantV[0] = 1; wantDest[0] = 1;
        for (int c = 0; c < 5; c++) begin
            idle();
            stall = (c < 2);
            if (c == 0) begin
                vectors++;
                if ({wbValidB, wbDestB} !== {1'b1, 4'd1} || obsB !== expB) begin
                    miscompares++;
                    $display("FAIL lat3_first got=%h want=%h", obsB, expB);
                end
            end
            tick();
            wantV[c + 1]    = (c < 4);
            wantDest[c + 1] = (c < 2) ? 4'd1 : (c == 2) ? 4'd2 : (c == 3) ? 4'd3 : 4'd0;
            vectors++;
            if ({wbValidB, wbDestB} !== {wantV[c + 1], wantDest[c + 1]} ||
                {obsA, obsB} !== {expA, expB}) begin
                miscompares++;
                $display("FAIL lat3_step%0d got A=%h B=%h want A=%h B=%h dest=%0d",
                         c, obsA, obsB, expA, expB, wantDest[c + 1]);
            end
        end
        drain("latency3");
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h60, 8'h00, 32'h11111111, 32'h0);
        tick();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h60, 8'h00, 32'hDEADBEEF, 32'h0);
        flush = 1'b1;
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h2, 8'h60, 8'h00, 32'h0, 32'h0);
        tick();
        vectors++;
        if (obsA !== {1'b1, 1'b1, 4'd2, 32'h11111111}) begin
            miscompares++;
            $display("FAIL flush_store got=%h want=%h", obsA, {1'b1, 1'b1, 4'd2, 32'h11111111});
        end
        // Loads in flight, then a flush that also carries a load.
        tick();
        flush = 1'b1;
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({wbValidA, wbValidB} !== 2'b00 || {obsA, obsB} !== {expA, expB}) begin
                miscompares++;
                $display("FAIL flush_inflight%0d got A=%h B=%h want valid=0", c, obsA, obsB);
            end
            tick();
        end
        // Reset with a stalled store pending. The store must not land.
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h70, 8'h00, 32'hCAFEF00D, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h4, 8'h70, 8'h00, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 8'h70, 8'h00, 32'h0BADBAD0, 32'h0);
        reset = 1'b1; stall = 1'b1;
        tick();
        vectors++;
        if ({obsA, obsB} !== 76'h0) begin
            miscompares++;
            $display("FAIL reset_midstream got A=%h B=%h want 0", obsA, obsB);
        end
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h4, 8'h70, 8'h00, 32'h0, 32'h0);
        tick();
        vectors++;
        if (obsA !== {1'b1, 1'b1, 4'd4, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL reset_keeps_mem got=%h want=%h", obsA, {1'b1, 1'b1, 4'd4, 32'hCAFEF00D});
        end
        drain("flush_reset");
    endtask

    task automatic test_rdw();
        drive(1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0, 4'h0, 8'h30, 8'h00, 32'h44332211, 32'h0);
        tick();
        drive(1'b1, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b1, 4'hA, 8'h30, 8'h00, 32'hDDCCBBAA, 32'h0);
        tick();
        vectors++;
        if (obsA !== {1'b1, 1'b1, 4'hA, 32'h4433BBAA} || obsA !== expA) begin
            miscompares++;
            $display("FAIL rdw got=%h want=%h", obsA, {1'b1, 1'b1, 4'hA, 32'h4433BBAA});
        end
        drain("rdw");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
                  {4'($urandom), 4'($urandom_range(0, 7))}, {4'($urandom), 4'($urandom_range(0, 7))},
                  $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
            vectors++;
            if ({obsA, obsB} !== {expA, expB}) begin
                miscompares++;
                $display("FAIL random%0d got A=%h B=%h want A=%h B=%h", c, obsA, obsB, expA, expB);
            end
        end
        drain("random");
    endtask

    initial begin
        qA.push_back('0);
        repeat (3) qB.push_back('0);
        expA = '0; expB = '0;
        idle();
        test_reset();
        test_fill();
        test_store_load();
        test_partial_mask();
        test_broadcast();
        test_latency3();
        test_flush_reset();
        test_rdw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
